// File: rtl/spike_mon_pkg.sv
// Shared ISI state encoding and default parameter values for the spike rate monitor.
package spike_mon_pkg;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } isi_state_t;

  localparam int DEF_WINDOW_LEN = 256;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_ISI_W      = 12;
  localparam int DEF_BURST_ISI  = 8;

endpackage

// File: rtl/spike_edge_det.sv
// Rising-edge detector on spike_in against a registered copy; edge is same-cycle (0 latency).
// No backpressure: one pulse per low-to-high transition, held-high input yields a single edge.
module spike_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) spike_q <= 1'b0;
    else       spike_q <= spike_in;
  end

  // spike_q clears on reset, so a spike already high at release counts as an edge
  assign spike_edge = spike_in & ~spike_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed spike rate / peak state and inter-spike interval monitor; all outputs 1 cycle after the event.
// No backpressure (valids are single-cycle pulses). Burst flag logic exists only with SPIKE_MON_BURST_EN.
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int WINDOW_LEN = DEF_WINDOW_LEN,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ISI_W      = DEF_ISI_W,
  parameter int BURST_ISI  = DEF_BURST_ISI
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic [7:0]       state_in,
  output logic [CNT_W-1:0] rate_count,
  output logic [7:0]       peak_state,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             burst
);

  localparam int               WIN_W     = $clog2(WINDOW_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ISI_W-1:0] TIMER_MAX = '1;

  if (WINDOW_LEN < 2 || BURST_ISI < 0) begin : g_param_check
    $error("spike_rate_monitor: WINDOW_LEN must be >= 2 and BURST_ISI >= 0");
  end

  logic spike_edge;

  spike_edge_det u_edge_det (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  // Rate window
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_acc;
  logic [CNT_W-1:0] acc_next;
  logic [7:0]       peak_trk;
  logic [7:0]       peak_next;
  logic             win_last;

  assign win_last  = (win_cnt == WIN_LAST);
  assign acc_next  = (spike_edge && (spike_acc != CNT_MAX)) ? spike_acc + CNT_W'(1) : spike_acc;
  assign peak_next = (state_in > peak_trk) ? state_in : peak_trk;

  // The terminal cycle's own edge and state are folded into the latched result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      spike_acc  <= '0;
      peak_trk   <= '0;
      rate_count <= '0;
      peak_state <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= win_last;
      if (win_last) begin
        win_cnt    <= '0;
        spike_acc  <= '0;
        peak_trk   <= '0;
        rate_count <= acc_next;
        peak_state <= peak_next;
      end else begin
        win_cnt    <= win_cnt + WIN_W'(1);
        spike_acc  <= acc_next;
        peak_trk   <= peak_next;
      end
    end
  end

  // Inter-spike interval
  isi_state_t       state;
  isi_state_t       state_next;
  logic [ISI_W-1:0] timer;
  logic [ISI_W-1:0] timer_next;
  logic [ISI_W-1:0] isi_next;
  logic             isi_valid_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_FIRST;
      timer     <= '0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      isi       <= isi_next;
      isi_valid <= isi_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    isi_next       = isi;
    isi_valid_next = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (spike_edge) begin
          state_next = MEASURE;
          timer_next = ISI_W'(1);
        end
      end
      MEASURE: begin
        // An edge on the last countable cycle wins over the timeout
        if (spike_edge) begin
          isi_next       = timer;
          isi_valid_next = 1'b1;
          timer_next     = ISI_W'(1);
        end else if (timer == TIMER_MAX) begin
          state_next = WAIT_FIRST;
          timer_next = '0;
        end else begin
          timer_next = timer + ISI_W'(1);
        end
      end
      default: state_next = WAIT_FIRST;
    endcase
  end

`ifdef SPIKE_MON_BURST_EN
  localparam int               TIMER_MAX_I = (1 << ISI_W) - 1;
  localparam logic [ISI_W-1:0] BURST_THR   =
    ISI_W'((BURST_ISI >= TIMER_MAX_I) ? TIMER_MAX_I : BURST_ISI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst <= 1'b0;
    end else if (isi_valid_next) begin
      burst <= (timer <= BURST_THR);
    end else if ((state == MEASURE) && (state_next == WAIT_FIRST)) begin
      burst <= 1'b0;
    end
  end
`else
  assign burst = 1'b0;
`endif

endmodule

// File: doc/spike_rate_monitor.md
SPIKE_RATE_MONITOR -- requirements
Module: spike_rate_monitor

Interface
REQ-001: Parameter WINDOW_LEN, default 256, rate-window length in clock cycles (>=2).
REQ-002: Parameter CNT_W, default 8, width of spike-count output.
REQ-003: Parameter ISI_W, default 12, width of inter-spike-interval output.
REQ-004: Parameter BURST_ISI, default 8, ISI threshold (cycles) for burst classification.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: spike_in  input  1  spike pulse from upstream neuron; may stay high for several cycles.
REQ-008: state_in  input  8  upstream neuron membrane state byte.
REQ-009: rate_count  output  CNT_W  spike count of last completed window.
REQ-010: peak_state  output  8  maximum state_in seen in last completed window (unsigned).
REQ-011: rate_valid  output  1  one-cycle pulse when rate_count/peak_state update.
REQ-012: isi  output  ISI_W  last measured inter-spike interval in cycles.
REQ-013: isi_valid  output  1  one-cycle pulse when isi updates.
REQ-014: burst  output  1  burst classification flag.

Function
REQ-015: Spike event = rising edge: spike_in high in cycle t and low in cycle t-1 (registered copy); held-high spike counts once.
REQ-016: Window counter runs 0..WINDOW_LEN-1 continuously from reset, wrapping to 0.
REQ-017: Per-window spike accumulator saturates at 2^CNT_W-1; no wrap.
REQ-018: On terminal window cycle, rate_count <= accumulator including any edge in that same cycle; accumulator <= 0; rate_valid high next cycle only.
REQ-019: peak_state tracks max of state_in over every window cycle, including terminal cycle, latched with rate_count; tracker restarts from 0.
REQ-020: ISI FSM states: WAIT_FIRST, MEASURE.
REQ-021: WAIT_FIRST: on edge -> MEASURE, timer <= 1; no output change.
REQ-022: MEASURE, no edge: timer <= timer+1; at timer = 2^ISI_W-1 without edge -> WAIT_FIRST, no isi_valid (timeout).
REQ-023: MEASURE, edge: isi <= timer (= t2-t1), isi_valid pulses next cycle, timer <= 1, stay MEASURE.
REQ-024: Edge coinciding with timeout cycle: treated as edge (REQ-023), no timeout.
REQ-025: All outputs registered; latency edge-to-isi_valid and terminal-cycle-to-rate_valid = 1 cycle.
REQ-026: Window and ISI logic independent; simultaneous rate_valid and isi_valid allowed.

Reset
REQ-027: Asserting reset, asynchronously: all outputs 0, FSM WAIT_FIRST, window counter 0, accumulator 0, peak tracker 0, timer 0, registered spike 0.
REQ-028: spike_in already high on first cycle after reset release counts as an edge.
REQ-029: Reset mid-window or mid-ISI discards partial results; no valid pulse issued.

Configuration
REQ-030: Macro SPIKE_MON_BURST_EN defined: burst <= 1 on isi_valid with isi <= BURST_ISI; burst <= 0 on isi_valid with isi > BURST_ISI or on timeout.
REQ-031: Macro undefined: burst tied 0, port retained, no burst logic synthesized.

Structure
REQ-032: Shared package spike_mon_pkg holds FSM state enum (WAIT_FIRST, MEASURE) and default parameter constants.
REQ-033: One sub-module spike_edge_det (registered rising-edge detector, async active-high reset) instantiated once.

Verification
REQ-034: WINDOW_LEN=16; 3 single-cycle spikes in window 0 -> rate_valid at cycle 16, rate_count=3.
REQ-035: spike_in held high 5 cycles -> one event; edges at cycles 10 and 17 -> isi=7, isi_valid one cycle at 18.
REQ-036: Edge exactly on window terminal cycle 15 -> counted in window 0; window 1 starts at 0.
REQ-037: ISI_W=4, single edge, no further spikes -> timeout after 15 cycles, no isi_valid; next two edges 3 apart -> isi=3.
REQ-038: SPIKE_MON_BURST_EN, BURST_ISI=8: ISIs 5 then 12 -> burst 1 then 0; macro undefined -> burst always 0.
REQ-039: reset pulse mid-MEASURE and mid-window -> all outputs 0 immediately, no valid pulses until new complete window/ISI.
